// File: rtl/led_panel_pkg.sv
// Shared types and constants for the LED panel scan scheduler.
// Holds state encoding, bus widths, pin polarities and the row-count derivation.
package led_panel_pkg;

    localparam int ROW_W   = 6;
    localparam int PLANE_W = 3;
    localparam int RMAX_W  = 3;

    localparam logic LATCH_ACTIVE = 1'b0;
    localparam logic BLANK_ON     = 1'b1;

    localparam logic [2:0] ENC_IDLE  = 3'd0;
    localparam logic [2:0] ENC_SHIFT = 3'd1;
    localparam logic [2:0] ENC_WAIT  = 3'd2;
    localparam logic [2:0] ENC_LATCH = 3'd3;
    localparam logic [2:0] ENC_SHOW  = 3'd4;
    localparam logic [2:0] ENC_NEXT  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = ENC_IDLE,
        ST_SHIFT = ENC_SHIFT,
        ST_WAIT  = ENC_WAIT,
        ST_LATCH = ENC_LATCH,
        ST_SHOW  = ENC_SHOW,
        ST_NEXT  = ENC_NEXT
    } sched_state_t;

    // Row count is {rowmax,3'b111}+1, so the last row index is simply {rowmax,3'b111}.
    function automatic logic [ROW_W-1:0] last_row_of(input logic [RMAX_W-1:0] rowmax);
        return {rowmax, 3'b111};
    endfunction

endpackage

// File: rtl/led_panel_scan_sched_if.sv
// Start/done handshake between the scan scheduler and the column shifter.
interface led_panel_scan_sched_if;
    import led_panel_pkg::*;

    logic               shift_start;
    logic [ROW_W-1:0]   shift_row;
    logic [PLANE_W-1:0] shift_plane;
    logic               shift_done;

    modport master (output shift_start, output shift_row, output shift_plane, input shift_done);
    modport slave  (input shift_start, input shift_row, input shift_plane, output shift_done);

endinterface

// File: rtl/led_bcm_timer.sv
// Down-counting on-time timer for one bitplane; tc is high once the count reaches zero.
module led_bcm_timer #(
    parameter int ON_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [ON_W-1:0] load_val,
    output logic            tc
);

    logic [ON_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - ON_W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/led_panel_scan_sched.sv
// HUB-style LED panel scan scheduler with binary-coded modulation across bitplanes.
//  state | meaning
//  IDLE  | blanked, row address held in reset, waiting for enable
//  SHIFT | one-cycle shifter start for current row/plane
//  WAIT  | shifter clocking columns out, waiting for shift_done
//  LATCH | one-cycle active latch pulse, still blanked
//  SHOW  | LEDs on for BASE_ON<<plane cycles
//  NEXT  | blanked; advance plane/row, pulse aclk or arst on row change
module led_panel_scan_sched
    import led_panel_pkg::*;
#(
    parameter int PLANES  = 4,
    parameter int BASE_ON = 16,
    parameter int ON_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [RMAX_W-1:0]     rowmax_in,
    led_panel_scan_sched_if.master shifter,
    output logic                  latch_out,
    output logic                  blank_out,
    output logic                  aclk_out,
    output logic                  arst_out,
    output logic                  frame_start
);

    sched_state_t     state;
    logic [ROW_W-1:0] last_row;
    logic             timer_load;
    logic [ON_W-1:0]  timer_val;
    logic             timer_tc;

    assign timer_load = (state == ST_LATCH);
    assign timer_val  = (ON_W'(BASE_ON) << shifter.shift_plane) - ON_W'(1);

    led_bcm_timer #(.ON_W(ON_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .tc       (timer_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state               <= ST_IDLE;
            shifter.shift_start <= 1'b0;
            shifter.shift_row   <= '0;
            shifter.shift_plane <= '0;
            latch_out           <= ~LATCH_ACTIVE;
            blank_out           <= BLANK_ON;
            aclk_out            <= 1'b0;
            arst_out            <= 1'b1;
            frame_start         <= 1'b0;
            last_row            <= '0;
        end else begin
            shifter.shift_start <= 1'b0;
            frame_start         <= 1'b0;
            aclk_out            <= 1'b0;
            case (state)
                ST_IDLE: begin
                    blank_out <= BLANK_ON;
                    latch_out <= ~LATCH_ACTIVE;
                    arst_out  <= 1'b1;
                    if (enable) begin
                        shifter.shift_row   <= '0;
                        shifter.shift_plane <= '0;
                        last_row            <= last_row_of(rowmax_in);
                        shifter.shift_start <= 1'b1;
                        frame_start         <= 1'b1;
                        arst_out            <= 1'b0;
                        state               <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (shifter.shift_done) begin
                        latch_out <= LATCH_ACTIVE;
                        state     <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    latch_out <= ~LATCH_ACTIVE;
                    blank_out <= ~BLANK_ON;
                    state     <= ST_SHOW;
                end
                ST_SHOW: begin
                    // Row/plane advance here so the new address is already valid during NEXT.
                    if (timer_tc) begin
                        blank_out <= BLANK_ON;
                        state     <= ST_NEXT;
                        if (shifter.shift_plane != PLANE_W'(PLANES - 1)) begin
                            shifter.shift_plane <= shifter.shift_plane + PLANE_W'(1);
                        end else begin
                            shifter.shift_plane <= '0;
                            if (shifter.shift_row == last_row) begin
                                shifter.shift_row <= '0;
                                arst_out          <= 1'b1;
                                last_row          <= last_row_of(rowmax_in);
                            end else begin
                                shifter.shift_row <= shifter.shift_row + ROW_W'(1);
                                aclk_out          <= 1'b1;
                            end
                        end
                    end
                end
                ST_NEXT: begin
                    if (enable) begin
                        shifter.shift_start <= 1'b1;
                        frame_start         <= (shifter.shift_row == '0) && (shifter.shift_plane == '0);
                        arst_out            <= 1'b0;
                        state               <= ST_SHIFT;
                    end else begin
                        arst_out <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_panel_scan_sched.sv
// Directed bench for led_panel_scan_sched: shifter model with 10-cycle latency plus pin monitors.
module tb_led_panel_scan_sched;
    import led_panel_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] rowmax_in = 3'd0;
    logic       latch_out, blank_out, aclk_out, arst_out, frame_start;
    logic       model_done = 1'b0;
    logic       spurious = 1'b0;

    led_panel_scan_sched_if sif();
    assign sif.shift_done = model_done | spurious;

    led_panel_scan_sched #(.PLANES(4), .BASE_ON(16), .ON_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .rowmax_in   (rowmax_in),
        .shifter     (sif),
        .latch_out   (latch_out),
        .blank_out   (blank_out),
        .aclk_out    (aclk_out),
        .arst_out    (arst_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Shifter stand-in: shift_done pulses 10 cycles after shift_start.
    int model_cnt = 0;
    always @(negedge clk) begin
        model_done = 1'b0;
        if (!reset) model_cnt = 0;
        else if (sif.shift_start) model_cnt = 10;
        else if (model_cnt > 0) begin
            model_cnt--;
            if (model_cnt == 0) model_done = 1'b1;
        end
    end

    int n_start = 0, n_frame = 0, n_aclk = 0, n_arst = 0, n_latch = 0, n_viol = 0;
    int run = 0, cur_max = 0, frame_max_prev = 0;
    int last_row_s = 0, last_plane_s = 0;
    int runs_q[$];
    int st_row_q[$];
    int st_plane_q[$];
    logic arst_prev = 1'b1, latch_prev = 1'b1;
    logic [5:0] row_prev = '0;

    always @(negedge clk) begin
        if (frame_start) begin
            n_frame++;
            frame_max_prev = cur_max;
            cur_max = 0;
            if (!sif.shift_start) n_viol++;
        end
        if (sif.shift_start) begin
            n_start++;
            last_row_s = int'(sif.shift_row);
            last_plane_s = int'(sif.shift_plane);
            st_row_q.push_back(last_row_s);
            st_plane_q.push_back(last_plane_s);
            if (last_row_s > cur_max) cur_max = last_row_s;
        end
        if (aclk_out) n_aclk++;
        if (arst_out && !arst_prev) n_arst++;
        arst_prev = arst_out;
        if (!latch_out && latch_prev) n_latch++;
        latch_prev = latch_out;
        if (!blank_out) run++;
        else if (run != 0) begin
            runs_q.push_back(run);
            run = 0;
        end
        if (aclk_out && arst_out) n_viol++;
        if (!latch_out && !blank_out) n_viol++;
        if (sif.shift_row != row_prev && !blank_out) n_viol++;
        row_prev = sif.shift_row;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int cur_val(input int sel);
        case (sel)
            0: return n_start;
            1: return n_frame;
            2: return int'(blank_out);
            3: return runs_q.size();
            default: return -1;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int target, input int budget, input string tag);
        int k = 0;
        while (cur_val(sel) != target && k < budget) begin
            tick();
            k++;
        end
        check_val(tag, cur_val(sel), target);
    endtask

    function automatic int last_run();
        if (runs_q.size() == 0) return -1;
        return runs_q[runs_q.size() - 1];
    endfunction

    int a0, r0, a3, r3, s, s5, f, l0, s6, s7;
    int exp_on[4];

    initial begin
        exp_on[0] = 16; exp_on[1] = 32; exp_on[2] = 64; exp_on[3] = 128;

        // Reset held for three edges, enable low.
        repeat (3) tick();
        check_val("rst_blank", blank_out, 1);
        check_val("rst_latch", latch_out, 1);
        check_val("rst_arst", arst_out, 1);
        check_val("rst_aclk", aclk_out, 0);
        reset = 1'b1;
        repeat (5) tick();
        check_val("idle_no_start", n_start, 0);
        check_val("idle_blank", blank_out, 1);
        check_val("idle_arst", arst_out, 1);

        // First row, four planes with doubling on-time.
        a0 = n_aclk;
        r0 = n_arst;
        enable = 1'b1;
        wait_for(3, 4, 1200, "t2_runs_wait");
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("t2_start_row%0d", i), st_row_q[i], 0);
            check_val($sformatf("t2_start_plane%0d", i), st_plane_q[i], i);
            check_val($sformatf("t2_on_run%0d", i), runs_q[i], exp_on[i]);
        end
        check_val("t2_frame_cnt", n_frame, 1);

        // Full 8-row frame.
        wait_for(1, 2, 3000, "t3_frame_wait");
        check_val("t3_aclk_cnt", n_aclk - a0, 7);
        check_val("t3_arst_cnt", n_arst - r0, 1);
        check_val("t3_rows", frame_max_prev, 7);

        // rowmax 3 takes effect at the next wrap; changing back mid-frame waits another wrap.
        rowmax_in = 3'd3;
        wait_for(1, 3, 3000, "t4_frame3_wait");
        check_val("t4_rows_f2", frame_max_prev, 7);
        a3 = n_aclk;
        r3 = n_arst;
        repeat (100) tick();
        rowmax_in = 3'd0;
        wait_for(1, 4, 10000, "t4_frame4_wait");
        check_val("t4_rows_f3", frame_max_prev, 31);
        check_val("t4_aclk_f3", n_aclk - a3, 31);
        check_val("t4_arst_f3", n_arst - r3, 1);
        wait_for(1, 5, 3000, "t4_frame5_wait");
        check_val("t4_rows_f4", frame_max_prev, 7);

        // Enable dropped during SHOW of plane 2.
        s = n_start;
        wait_for(0, s + 2, 200, "t5_plane2_wait");
        check_val("t5_plane2", last_plane_s, 2);
        wait_for(2, 0, 30, "t5_show_wait");
        repeat (5) tick();
        enable = 1'b0;
        s5 = n_start;
        wait_for(2, 1, 100, "t5_show_end_wait");
        check_val("t5_full_show", last_run(), 64);
        repeat (20) tick();
        check_val("t5_no_start", n_start, s5);
        check_val("t5_idle_blank", blank_out, 1);
        check_val("t5_idle_arst", arst_out, 1);
        check_val("t5_idle_plane", int'(sif.shift_plane), 3);
        f = n_frame;
        enable = 1'b1;
        wait_for(0, s5 + 1, 10, "t5_relaunch_wait");
        check_val("t5_relaunch_row", last_row_s, 0);
        check_val("t5_relaunch_plane", last_plane_s, 0);
        check_val("t5_relaunch_frame", n_frame, f + 1);

        // Spurious done during SHOW, then reset while in WAIT.
        l0 = n_latch;
        wait_for(2, 0, 30, "t6_show_wait");
        repeat (3) tick();
        spurious = 1'b1;
        tick();
        spurious = 1'b0;
        wait_for(2, 1, 50, "t6_show_end_wait");
        check_val("t6_show_len", last_run(), 16);
        check_val("t6_latch_cnt", n_latch - l0, 1);
        s6 = n_start;
        wait_for(0, s6 + 1, 30, "t6_plane1_wait");
        check_val("t6_plane1", last_plane_s, 1);
        repeat (3) tick();
        reset = 1'b0;
        enable = 1'b0;
        tick();
        check_val("t6_rst_start", sif.shift_start, 0);
        check_val("t6_rst_plane", int'(sif.shift_plane), 0);
        check_val("t6_rst_row", int'(sif.shift_row), 0);
        check_val("t6_rst_latch", latch_out, 1);
        check_val("t6_rst_blank", blank_out, 1);
        check_val("t6_rst_aclk", aclk_out, 0);
        check_val("t6_rst_arst", arst_out, 1);
        check_val("t6_rst_frame", frame_start, 0);
        reset = 1'b1;
        s7 = n_start;
        repeat (15) tick();
        check_val("t6_post_rst_idle", n_start, s7);
        check_val("t6_post_rst_blank", blank_out, 1);

        check_val("pin_rules", n_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
